// File: rtl/dm_mmio_bridge.sv
// dm_mmio_bridge: data-side memory stage for the core's M stage.
// Holds the data RAM and a small MMIO page (GPIO, cycle counter,
// byte TX FIFO with drain handshake, status). Reads are combinational
// so load data is ready at the M->W edge; writes commit at that edge.
// Optional timer-compare interrupt is built when TIMER_CMP_EN is defined.
//
// TX drain handshake: tx_valid is high whenever the FIFO holds a byte and
// tx_data is the head byte; the head is consumed at a rising edge where
// tx_valid && tx_ready. tx_data does not depend on tx_ready.
module dm_mmio_bridge #(
  parameter int          DM_WORDS  = 4096,
  parameter int          TX_DEPTH  = 4,
  parameter logic [15:0] MMIO_BASE = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [3:0]  w_en,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int          AW         = $clog2(DM_WORDS);
  localparam int          PW         = $clog2(TX_DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [31:0] DM_WORDS_U = 32'(DM_WORDS);

  // Register word offsets inside the MMIO page
  localparam logic [9:0] OFF_GPIO   = 10'h000;
  localparam logic [9:0] OFF_CNT    = 10'h001;
  localparam logic [9:0] OFF_TX     = 10'h002;
  localparam logic [9:0] OFF_STATUS = 10'h003;
  localparam logic [9:0] OFF_CMP    = 10'h004;

  // Replace only the enabled byte lanes of a word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // ------------------------------------------------------------------
  // Address decode (addr[1:0] are ignored: all accesses are word-aligned)
  // ------------------------------------------------------------------
  logic [13:0]   word_idx;
  logic [AW-1:0] ram_idx;
  logic [9:0]    reg_off;
  logic          mmio_sel;
  logic          ram_sel;
  logic          sel_gpio;
  logic          sel_cnt;
  logic          sel_tx;
  logic          sel_status;
  logic          sel_cmp;
  logic          unmapped;
  logic          wr;
  logic          addr_lsb_unused;

  assign word_idx        = addr[15:2];
  assign ram_idx         = word_idx[AW-1:0];
  assign reg_off         = addr[11:2];
  assign addr_lsb_unused = ^addr[1:0];
  assign wr              = |w_en;

  // MMIO page takes priority so it can never be shadowed by a large RAM
  assign mmio_sel   = (addr[15:12] == MMIO_BASE[15:12]);
  assign ram_sel    = !mmio_sel && ({18'd0, word_idx} < DM_WORDS_U);
  assign sel_gpio   = mmio_sel && (reg_off == OFF_GPIO);
  assign sel_cnt    = mmio_sel && (reg_off == OFF_CNT);
  assign sel_tx     = mmio_sel && (reg_off == OFF_TX);
  assign sel_status = mmio_sel && (reg_off == OFF_STATUS);
`ifdef TIMER_CMP_EN
  assign sel_cmp    = mmio_sel && (reg_off == OFF_CMP);
`else
  assign sel_cmp    = 1'b0;
`endif
  assign unmapped   = !(ram_sel || sel_gpio || sel_cnt || sel_tx || sel_status || sel_cmp);

  // ------------------------------------------------------------------
  // Data RAM (not reset)
  // ------------------------------------------------------------------
  logic [31:0] mem [DM_WORDS];

  // Byte-lane write into the addressed RAM word at the clock edge
  always_ff @(posedge clk) begin
    if (ram_sel && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_en[i]) mem[ram_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // ------------------------------------------------------------------
  // GPIO and cycle counter
  // ------------------------------------------------------------------
  logic [31:0] cycle_cnt;

  // GPIO output register, byte-masked writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out <= 32'd0;
    end else if (sel_gpio && wr) begin
      gpio_out <= lane_merge(gpio_out, w_data, w_en);
    end
  end

  // Free-running counter; a full-word write replaces that cycle's increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= 32'd0;
    end else if (sel_cnt && (w_en == 4'hF)) begin
      cycle_cnt <= w_data;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // ------------------------------------------------------------------
  // TX FIFO
  // ------------------------------------------------------------------
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] tx_cnt;
  logic          tx_full;
  logic          tx_empty;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;

  assign tx_full  = (tx_cnt == CW'(TX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push_req = sel_tx && w_en[0];
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push     = push_req && (!tx_full || pop);
  assign drop     = push_req && tx_full && !pop;

  // FIFO storage write (not reset; only entries behind the pointers are visible)
  always_ff @(posedge clk) begin
    if (push) tx_mem[wr_ptr] <= w_data[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (pop && !push) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Sticky status flags
  // ------------------------------------------------------------------
  logic overflow;
  logic err;

  // Overflow sets on a dropped push, err on a write to an unmapped address;
  // any write to STATUS clears both (these events use different addresses)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (drop)                   overflow <= 1'b1;
      else if (sel_status && wr)  overflow <= 1'b0;
      if (unmapped && wr)         err <= 1'b1;
      else if (sel_status && wr)  err <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Optional timer compare
  // ------------------------------------------------------------------
  logic        irq_en;
  logic [31:0] cmp;

`ifdef TIMER_CMP_EN
  logic irq_q;
  logic cmp_wr;

  assign cmp_wr = sel_cmp && wr;
  assign irq    = irq_q;

  // CMP register (byte-masked) and irq_en in STATUS lane 2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp    <= 32'd0;
      irq_en <= 1'b0;
    end else begin
      if (cmp_wr)                cmp    <= lane_merge(cmp, w_data, w_en);
      if (sel_status && w_en[2]) irq_en <= w_data[16];
    end
  end

  // Interrupt latches one cycle after a match; a CMP write or irq_en=0 clears
  // it and wins over a simultaneous match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else if (cmp_wr || !irq_en) begin
      irq_q <= 1'b0;
    end else if (cycle_cnt == cmp) begin
      irq_q <= 1'b1;
    end
  end
`else
  assign cmp    = 32'd0;
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  logic [31:0] status_word;

  // STATUS layout: full, empty, overflow, err, count[8:4], irq_en at bit 16
  always_comb begin
    status_word        = 32'd0;
    status_word[0]     = tx_full;
    status_word[1]     = tx_empty;
    status_word[2]     = overflow;
    status_word[3]     = err;
    status_word[8:4]   = 5'(tx_cnt);
    status_word[16]    = irq_en;
  end

  // Combinational load data; TX_DATA and unmapped addresses read 0
  always_comb begin
    r_data = 32'd0;
    if (ram_sel)         r_data = mem[ram_idx];
    else if (sel_gpio)   r_data = gpio_out;
    else if (sel_cnt)    r_data = cycle_cnt;
    else if (sel_status) r_data = status_word;
    else if (sel_cmp)    r_data = cmp;
  end

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Testbench for dm_mmio_bridge: directed vector table, hand-written
// reset/timer sequences, and randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_dm_mmio_bridge;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [3:0]  w_en = 4'd0;
  logic [31:0] w_data = 32'd0;
  logic        tx_ready = 1'b0;
  logic [31:0] r_data;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        irq;

  always #5 clk = ~clk;

  dm_mmio_bridge #(
    .DM_WORDS (4096),
    .TX_DEPTH (DEPTH),
    .MMIO_BASE(16'hF000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .w_en    (w_en),
    .w_data  (w_data),
    .r_data  (r_data),
    .gpio_out(gpio_out),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .irq     (irq)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [int];
  logic [31:0] m_mask [int];
  logic [31:0] m_gpio, m_cnt, m_cmp;
  bit          m_ovf, m_err, m_irq_en, m_irq;
  logic [7:0]  exp_q [$];

  function automatic logic [31:0] lanes_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] m;
    m = lanes_mask(be);
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] m_status();
    int s;
    s = ((exp_q.size() == DEPTH) ? 1 : 0) + ((exp_q.size() == 0) ? 2 : 0)
      + (m_ovf ? 4 : 0) + (m_err ? 8 : 0) + exp_q.size() * 16 + (m_irq_en ? 65536 : 0);
    return 32'(s);
  endfunction

  task automatic model_reset();
    m_gpio = 0; m_cnt = 0; m_cmp = 0;
    m_ovf = 0; m_err = 0; m_irq_en = 0; m_irq = 0;
    exp_q.delete();
  endtask

  // Expected load value and which of its bits are known
  task automatic model_read(input logic [15:0] a, output logic [31:0] v, output logic [31:0] known);
    int w;
    logic [11:0] off;
    w = int'(a >> 2);
    off = {a[11:2], 2'b00};
    v = 0; known = 32'hFFFF_FFFF;
    if (a[15:12] == 4'hF) begin
      case (off)
        12'h000: v = m_gpio;
        12'h004: v = m_cnt;
        12'h00C: v = m_status();
`ifdef TIMER_CMP_EN
        12'h010: v = m_cmp;
`endif
        default: v = 0;
      endcase
    end else if (a < 16'h4000) begin
      if (m_mem.exists(w)) begin v = m_mem[w]; known = m_mask[w]; end
      else known = 0;
    end
  endtask

  task automatic model_step(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd, input logic rdy);
    int w;
    logic [11:0] off;
    bit pop, full, push, cmp_wr, nxt_irq;
    logic [31:0] nxt_cnt;
    w = int'(a >> 2);
    off = {a[11:2], 2'b00};
    pop = (exp_q.size() > 0) && rdy;
    full = (exp_q.size() == DEPTH);
    push = 0; cmp_wr = 0;
    nxt_cnt = m_cnt + 1;
    nxt_irq = m_irq_en && (m_irq || (m_cnt == m_cmp));
    if (we != 0) begin
      if (a[15:12] == 4'hF) begin
        case (off)
          12'h000: m_gpio = merge(m_gpio, wd, we);
          12'h004: if (we == 4'hF) nxt_cnt = wd;
          12'h008: push = we[0];
          12'h00C: begin
            m_ovf = 0; m_err = 0;
`ifdef TIMER_CMP_EN
            if (we[2]) m_irq_en = wd[16];
`endif
          end
`ifdef TIMER_CMP_EN
          12'h010: begin m_cmp = merge(m_cmp, wd, we); cmp_wr = 1; end
`endif
          default: m_err = 1;
        endcase
      end else if (a < 16'h4000) begin
        if (!m_mem.exists(w)) begin m_mem[w] = 0; m_mask[w] = 0; end
        m_mem[w]  = merge(m_mem[w], wd, we);
        m_mask[w] = m_mask[w] | lanes_mask(we);
      end else begin
        m_err = 1;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else exp_q.push_back(wd[7:0]);
    end
    m_cnt = nxt_cnt;
    m_irq = cmp_wr ? 1'b0 : nxt_irq;
  endtask

  // ---------------- driver tasks (entered at a falling edge) ----------------
  task automatic apply(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd, input logic rdy);
    logic [31:0] ev, km;
    addr = a; w_en = we; w_data = wd; tx_ready = rdy;
    #1;
    model_read(a, ev, km);
    if (km != 0) check("r_data", r_data & km, ev & km);
    check("tx_valid", 32'(tx_valid), (exp_q.size() > 0) ? 32'd1 : 32'd0);
    check("tx_data", 32'(tx_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
    check("gpio_out", gpio_out, m_gpio);
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic advance(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd, input logic rdy);
    @(posedge clk);
    model_step(a, we, wd, rdy);
    @(negedge clk);
  endtask

  task automatic cycle(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd, input logic rdy);
    apply(a, we, wd, rdy);
    advance(a, we, wd, rdy);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        rdy;
    bit          chk;
    logic [31:0] er;
    logic        ev;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                              input logic rdy, input bit chk, input logic [31:0] er,
                              input logic ev, input logic [7:0] ed);
    vec_t v;
    v.a = a; v.we = we; v.wd = wd; v.rdy = rdy; v.chk = chk; v.er = er; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  initial begin
    // RAM byte-lane merge and read-during-write
    tbl.push_back(mk(16'h0010, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(16'h0010, 4'h2, 32'h00001200, 0, 1, 32'hDEADBEEF, 0, 8'h00));
    tbl.push_back(mk(16'h0010, 4'h0, 32'h0, 0, 1, 32'hDEAD12EF, 0, 8'h00));
    // GPIO and cycle counter wrap
    tbl.push_back(mk(16'hF000, 4'h1, 32'h000000A5, 0, 1, 32'h0, 0, 8'h00));
    tbl.push_back(mk(16'hF000, 4'h0, 32'h0, 0, 1, 32'h000000A5, 0, 8'h00));
    tbl.push_back(mk(16'hF004, 4'hF, 32'hFFFFFFFE, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(16'hF004, 4'h0, 32'h0, 0, 1, 32'hFFFFFFFE, 0, 8'h00));
    tbl.push_back(mk(16'hF004, 4'h0, 32'h0, 0, 1, 32'hFFFFFFFF, 0, 8'h00));
    tbl.push_back(mk(16'hF004, 4'h0, 32'h0, 0, 1, 32'h00000000, 0, 8'h00));
    tbl.push_back(mk(16'hF004, 4'h3, 32'h00001234, 0, 1, 32'h00000001, 0, 8'h00));
    tbl.push_back(mk(16'hF004, 4'h0, 32'h0, 0, 1, 32'h00000002, 0, 8'h00));
    // Five pushes into a 4-deep FIFO with the consumer stalled
    tbl.push_back(mk(16'hF008, 4'h1, 32'h41, 0, 1, 32'h0, 0, 8'h00));
    tbl.push_back(mk(16'hF008, 4'h1, 32'h42, 0, 1, 32'h0, 1, 8'h41));
    tbl.push_back(mk(16'hF008, 4'h1, 32'h43, 0, 1, 32'h0, 1, 8'h41));
    tbl.push_back(mk(16'hF008, 4'h1, 32'h44, 0, 1, 32'h0, 1, 8'h41));
    tbl.push_back(mk(16'hF008, 4'h1, 32'h45, 0, 1, 32'h0, 1, 8'h41));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 0, 1, 32'h45, 1, 8'h41));
    tbl.push_back(mk(16'hF008, 4'h0, 32'h0, 0, 1, 32'h0, 1, 8'h41));
    // Drain
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h45, 1, 8'h41));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h34, 1, 8'h42));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h24, 1, 8'h43));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h14, 1, 8'h44));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h06, 0, 8'h00));
    tbl.push_back(mk(16'hF00C, 4'hF, 32'h000000FF, 0, 1, 32'h06, 0, 8'h00));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 0, 1, 32'h02, 0, 8'h00));
    // Full FIFO with simultaneous push and pop
    tbl.push_back(mk(16'hF008, 4'h1, 32'h61, 0, 1, 32'h0, 0, 8'h00));
    tbl.push_back(mk(16'hF008, 4'h1, 32'h62, 0, 1, 32'h0, 1, 8'h61));
    tbl.push_back(mk(16'hF008, 4'h1, 32'h63, 0, 1, 32'h0, 1, 8'h61));
    tbl.push_back(mk(16'hF008, 4'h1, 32'h64, 0, 1, 32'h0, 1, 8'h61));
    tbl.push_back(mk(16'hF008, 4'h1, 32'h55, 1, 1, 32'h0, 1, 8'h61));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 0, 1, 32'h41, 1, 8'h62));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h41, 1, 8'h62));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h30, 1, 8'h63));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h20, 1, 8'h64));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h10, 1, 8'h55));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 1, 1, 32'h02, 0, 8'h00));
    // Unmapped writes set err; STATUS write clears it
    tbl.push_back(mk(16'hF020, 4'hF, 32'h12345678, 0, 1, 32'h0, 0, 8'h00));
    tbl.push_back(mk(16'hF020, 4'h0, 32'h0, 0, 1, 32'h0, 0, 8'h00));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 0, 1, 32'h0A, 0, 8'h00));
    tbl.push_back(mk(16'hF00C, 4'h1, 32'h0, 0, 1, 32'h0A, 0, 8'h00));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 0, 1, 32'h02, 0, 8'h00));
    tbl.push_back(mk(16'h4000, 4'hF, 32'h11111111, 0, 1, 32'h0, 0, 8'h00));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 0, 1, 32'h0A, 0, 8'h00));
    tbl.push_back(mk(16'hF00C, 4'hF, 32'h0, 0, 1, 32'h0A, 0, 8'h00));
    tbl.push_back(mk(16'hF00C, 4'h0, 32'h0, 0, 1, 32'h02, 0, 8'h00));
    // Top RAM word and ignored low address bits
    tbl.push_back(mk(16'h3FFC, 4'hF, 32'hCAFEF00D, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(16'h3FFE, 4'h0, 32'h0, 0, 1, 32'hCAFEF00D, 0, 8'h00));
    tbl.push_back(mk(16'h0013, 4'h0, 32'h0, 0, 1, 32'hDEAD12EF, 0, 8'h00));
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] ra;
    logic [3:0]  rwe;
    int          k;

    // Reset state
    model_reset();
    addr = 16'hF00C;
    repeat (2) @(negedge clk);
    #1;
    check("rst_status", r_data, 32'h00000002);
    check("rst_gpio", gpio_out, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    addr = 16'hF004;
    #1;
    check("rst_cycle_cnt", r_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].rdy);
      if (tbl[i].chk) check($sformatf("vec%0d_r_data", i), r_data, tbl[i].er);
      check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].ed));
      advance(tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].rdy);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 8; i++) cycle(16'(i * 4), 4'hF, $urandom, 1'b0);
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 17);
      case (k)
        0, 1, 2, 3, 4, 5, 6, 7: ra = 16'(k * 4);
        8:       ra = 16'h3FFC;
        9:       ra = 16'hF000;
        10:      ra = 16'hF004;
        11, 12:  ra = 16'hF008;
        13:      ra = 16'hF00C;
        14:      ra = 16'hF010;
        15:      ra = 16'hF020;
        16:      ra = 16'h4000;
        default: ra = 16'hFFFC;
      endcase
      ra[1:0] = 2'($urandom_range(0, 3));
      rwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      cycle(ra, rwe, $urandom, ($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset mid-drain
    cycle(16'hF00C, 4'hF, 32'h0, 1'b0);
    cycle(16'hF008, 4'h1, 32'h71, 1'b0);
    cycle(16'hF008, 4'h1, 32'h72, 1'b0);
    cycle(16'hF008, 4'h1, 32'h73, 1'b0);
    cycle(16'hF000, 4'hF, 32'hFF00FF00, 1'b0);
    cycle(16'hF004, 4'h0, 32'h0, 1'b1);
    addr = 16'hF004; w_en = 4'h0; tx_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("async_rst_tx_data", 32'(tx_data), 32'd0);
    check("async_rst_gpio", gpio_out, 32'd0);
    check("async_rst_cycle_cnt", r_data, 32'd0);
    @(negedge clk);
    check("held_rst_cycle_cnt", r_data, 32'd0);
    model_reset();
    rst = 1'b1;
    cycle(16'hF004, 4'h0, 32'h0, 1'b0);
    cycle(16'hF00C, 4'h0, 32'h0, 1'b0);

`ifdef TIMER_CMP_EN
    // Timer compare interrupt
    cycle(16'hF010, 4'hF, 32'd20, 1'b0);
    cycle(16'hF00C, 4'b0100, 32'h0001_0000, 1'b0);
    for (int i = 0; i < 40 && m_cnt != 32'd20; i++) cycle(16'hF004, 4'h0, 32'h0, 1'b0);
    apply(16'hF004, 4'h0, 32'h0, 1'b0);
    check("cnt_at_cmp", r_data, 32'd20);
    check("irq_before_rise", 32'(irq), 32'd0);
    advance(16'hF004, 4'h0, 32'h0, 1'b0);
    check("irq_rise", 32'(irq), 32'd1);
    cycle(16'hF004, 4'h0, 32'h0, 1'b0);
    check("irq_hold", 32'(irq), 32'd1);
    cycle(16'hF010, 4'hF, 32'd100, 1'b0);
    check("irq_clear_on_cmp_write", 32'(irq), 32'd0);
    cycle(16'hF00C, 4'h0, 32'h0, 1'b0);
`else
    // Without the timer, +0x10 is unmapped
    cycle(16'hF010, 4'hF, 32'd20, 1'b0);
    apply(16'hF00C, 4'h0, 32'h0, 1'b0);
    check("cmp_unmapped_err", r_data, 32'h0000000A);
    advance(16'hF00C, 4'h0, 32'h0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
